// File: rtl/ra_bist_march.sv
// rtl/ra_bist_march.sv - March C- BIST engine for a 64x72 two-read-port array
module ra_bist_march #(
  parameter int GENMODE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  test,
  input  logic        abort,
  output logic        rd0_enb,
  output logic        rd1_enb,
  output logic [5:0]  rd0_adr,
  output logic [5:0]  rd1_adr,
  output logic        wr0_enb,
  output logic [5:0]  wr0_adr,
  output logic [71:0] wr0_dat,
  input  logic [71:0] rd0_dat,
  input  logic [71:0] rd1_dat,
  output logic        busy,
  output logic        done,
  output logic [31:0] status
);

  if (GENMODE < 0) begin : g_genmode_unused
  end

  typedef enum logic [3:0] {
    S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DRAIN, S_DONE
  } state_t;

  state_t        state, next_state;
  logic [5:0]    adr, nxt_adr;
  logic          ph, nxt_ph;
  logic [7:0]    test_q;
  logic          cmp_vld, cmp_down;
  logic [71:0]   cmp_exp;
  logic [5:0]    cmp_adr;
  logic          fail_up, fail_down, bad_test, pass;
  logic [7:0]    err_cnt;
  logic [5:0]    fail_adr;

  logic          rd_en, wr_en, is_down;
  logic [71:0]   wdat, rexp, d0, d1;
  logic          test_ok, accept, aborting, miscmp, set_up, set_down;

  assign test_ok  = (test == 8'h00) || (test == 8'h01);
  assign accept   = (state == S_IDLE) && start && !abort;
  assign aborting = abort && (state != S_IDLE);
  assign d0       = test_q[0] ? (adr[0] ? {9{8'hAA}} : {9{8'h55}}) : 72'd0;
  assign d1       = ~d0;
  assign is_down  = (state == S_M3) || (state == S_M4) || (state == S_M5);

  always_comb begin
    next_state = state;
    nxt_adr    = adr;
    nxt_ph     = ph;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    wdat       = 72'd0;
    rexp       = 72'd0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = test_ok ? S_M0 : S_DONE;
          nxt_adr    = 6'd0;
          nxt_ph     = 1'b0;
        end
      end
      S_M0: begin
        wr_en   = 1'b1;
        wdat    = d0;
        nxt_adr = adr + 6'd1;
        if (adr == 6'h3F) next_state = S_M1;
      end
      S_M1, S_M2, S_M3, S_M4: begin
        // Two-cycle elements: ph=0 reads the old value, ph=1 writes its inverse
        if (!ph) begin
          rd_en = 1'b1;
          rexp  = ((state == S_M1) || (state == S_M3)) ? d0 : d1;
        end else begin
          wr_en = 1'b1;
          wdat  = ((state == S_M1) || (state == S_M3)) ? d1 : d0;
        end
        nxt_ph = ~ph;
        if (ph) begin
          nxt_adr = is_down ? adr - 6'd1 : adr + 6'd1;
          if (state == S_M1 && adr == 6'h3F) next_state = S_M2;
          if (state == S_M2 && adr == 6'h3F) begin
            next_state = S_M3;
            nxt_adr    = 6'h3F;
          end
          if (state == S_M3 && adr == 6'h00) next_state = S_M4;
          if (state == S_M4 && adr == 6'h00) next_state = S_M5;
        end
      end
      S_M5: begin
        rd_en   = 1'b1;
        rexp    = d0;
        nxt_adr = adr - 6'd1;
        if (adr == 6'h00) next_state = S_DRAIN;
      end
      S_DRAIN: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
    if (aborting) begin
      next_state = S_IDLE;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      wdat       = 72'd0;
    end
  end

  assign miscmp   = cmp_vld && ((rd0_dat != cmp_exp) || (rd1_dat != cmp_exp));
  assign set_up   = miscmp && !cmp_down;
  assign set_down = miscmp && cmp_down;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      adr       <= 6'd0;
      ph        <= 1'b0;
      test_q    <= 8'd0;
      cmp_vld   <= 1'b0;
      cmp_down  <= 1'b0;
      cmp_exp   <= 72'd0;
      cmp_adr   <= 6'd0;
      fail_up   <= 1'b0;
      fail_down <= 1'b0;
      bad_test  <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= 8'd0;
      fail_adr  <= 6'd0;
    end else begin
      state    <= next_state;
      adr      <= nxt_adr;
      ph       <= nxt_ph;
      cmp_vld  <= rd_en;
      cmp_exp  <= rexp;
      cmp_down <= is_down;
      cmp_adr  <= adr;
      if (miscmp) begin
        if (cmp_down) fail_down <= 1'b1;
        else          fail_up   <= 1'b1;
        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        if (err_cnt == 8'd0)  fail_adr <= cmp_adr;
      end
      // Final M5 compare lands on the DRAIN edge, so fold it into pass directly
      if (state == S_DRAIN && !abort)
        pass <= ~(fail_up | set_up) & ~(fail_down | set_down) & ~bad_test;
      if (aborting) pass <= 1'b0;
      if (accept) begin
        test_q    <= test;
        fail_up   <= 1'b0;
        fail_down <= 1'b0;
        bad_test  <= !test_ok;
        pass      <= 1'b0;
        err_cnt   <= 8'd0;
        fail_adr  <= 6'd0;
      end
    end
  end

  assign rd0_enb = rd_en;
  assign rd1_enb = rd_en;
  assign rd0_adr = rd_en ? adr : 6'd0;
  assign rd1_adr = rd_en ? adr : 6'd0;
  assign wr0_enb = wr_en;
  assign wr0_adr = wr_en ? adr : 6'd0;
  assign wr0_dat = wdat;
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);
  assign status  = {pass, fail_up, fail_down, bad_test, busy, 3'b000,
                    err_cnt, 2'b00, fail_adr, test_q};

endmodule

// File: tb/tb_ra_bist_march.sv
// tb/tb_ra_bist_march.sv - directed bench for ra_bist_march with a 64x72 array model
module tb_ra_bist_march;

  logic        clk, reset, start, abort;
  logic [7:0]  test;
  logic        rd0_enb, rd1_enb, wr0_enb, busy, done;
  logic [5:0]  rd0_adr, rd1_adr, wr0_adr;
  logic [71:0] wr0_dat, rd0_dat, rd1_dat;
  logic [31:0] status;

  logic [71:0] mem [64];
  logic        fault;

  int n_chk, n_fail;
  int cyc, nwr, nrd, adr_bad, zero_bad, first_up;
  logic [126:0] snap;
  logic [77:0]  w0, w1;

  ra_bist_march #(.GENMODE(0)) dut (
    .clk(clk), .reset(reset), .start(start), .test(test), .abort(abort),
    .rd0_enb(rd0_enb), .rd1_enb(rd1_enb), .rd0_adr(rd0_adr), .rd1_adr(rd1_adr),
    .wr0_enb(wr0_enb), .wr0_adr(wr0_adr), .wr0_dat(wr0_dat),
    .rd0_dat(rd0_dat), .rd1_dat(rd1_dat),
    .busy(busy), .done(done), .status(status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Array model: registered reads, optional bit 5 of address 0x12 stuck at 1
  always @(posedge clk) begin
    if (wr0_enb) mem[wr0_adr] <= wr0_dat;
    if (rd0_enb) rd0_dat <= mem[rd0_adr] | ((fault && rd0_adr == 6'h12) ? 72'h20 : 72'h0);
    if (rd1_enb) rd1_dat <= mem[rd1_adr] | ((fault && rd1_adr == 6'h12) ? 72'h20 : 72'h0);
  end

  function automatic logic [126:0] outs();
    return {wr0_dat, wr0_adr, rd0_adr, rd1_adr, wr0_enb, rd0_enb, rd1_enb, busy, done, status};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] t);
    @(negedge clk);
    start = 1'b1;
    test  = t;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the negedge of cycle 0; returns on the done cycle or after 2000 cycles
  task automatic run(input int abort_at, input int rst_at, input int restart_at, input int probe_at);
    logic [7:0] tsave;
    cyc = 0; nwr = 0; nrd = 0; adr_bad = 0; zero_bad = 0; first_up = -1;
    snap = '1; w0 = '0; w1 = '0;
    while (!done && cyc < 2000) begin
      if (wr0_enb) nwr++;
      if (rd0_enb) nrd++;
      if (rd0_enb !== rd1_enb || rd0_adr !== rd1_adr) adr_bad++;
      if (!wr0_enb && (wr0_adr !== 6'd0 || wr0_dat !== 72'd0)) zero_bad++;
      if (!rd0_enb && rd0_adr !== 6'd0) zero_bad++;
      if (status[30] && first_up < 0) first_up = cyc;
      if (cyc == 0) w0 = {wr0_adr, wr0_dat};
      if (cyc == 1) w1 = {wr0_adr, wr0_dat};
      if (cyc == probe_at) snap = outs();
      tsave = test;
      if (cyc == abort_at) abort = 1'b1;
      if (cyc == rst_at) reset = 1'b0;
      if (cyc == restart_at) begin
        start = 1'b1;
        test  = 8'h07;
      end
      @(negedge clk);
      abort = 1'b0; reset = 1'b1; start = 1'b0; test = tsave;
      cyc++;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b0; start = 1'b0; abort = 1'b0; test = 8'h00; fault = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 72'd0;
    rd0_dat = 72'd0; rd1_dat = 72'd0;

    repeat (3) @(negedge clk);
    check("reset_outs", outs(), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_outs", outs(), 0);

    // Solid background, ideal array
    pulse_start(8'h00);
    check("solid_busy_c0", busy, 1);
    run(-1, -1, -1, -1);
    check("solid_done_cyc", cyc, 641);
    check("solid_pass", status[31:27], 5'b10000);
    check("solid_err_cnt", status[23:16], 0);
    check("solid_writes", nwr, 320);
    check("solid_reads", nrd, 320);
    check("solid_rd_ports", adr_bad, 0);
    check("solid_idle_zero", zero_bad, 0);
    @(negedge clk);
    check("solid_done_pulse", {done, busy}, 2'b00);
    check("solid_hold", status, 32'h8000_0000);

    // Stuck-at-1 on bit 5 of address 0x12
    fault = 1'b1;
    pulse_start(8'h00);
    run(-1, -1, -1, -1);
    check("stuck_done_cyc", cyc, 641);
    check("stuck_first_up", first_up, 102);
    check("stuck_flags", status[31:28], 4'b0110);
    check("stuck_fail_adr", status[13:8], 6'h12);
    check("stuck_err_cnt", status[23:16], 3);
    fault = 1'b0;

    // Checkerboard background
    pulse_start(8'h01);
    run(-1, -1, -1, -1);
    check("ckb_wr_a0", w0, {6'h00, {9{8'h55}}});
    check("ckb_wr_a1", w1, {6'h01, {9{8'hAA}}});
    check("ckb_status", status, 32'h8000_0001);

    // Invalid test id
    pulse_start(8'h07);
    check("bad_done", {done, busy, rd0_enb, rd1_enb, wr0_enb}, 5'b10000);
    check("bad_status", status, 32'h1000_0007);
    @(negedge clk);
    check("bad_after", {done, busy, rd0_enb, rd1_enb, wr0_enb}, 5'b00000);

    // Abort mid-run, then a clean full run
    pulse_start(8'h00);
    run(300, -1, -1, 301);
    check("abort_no_done", cyc, 2000);
    check("abort_outs", snap, 0);
    pulse_start(8'h00);
    run(-1, -1, -1, -1);
    check("post_abort_cyc", cyc, 641);
    check("post_abort_status", status, 32'h8000_0000);
    check("post_abort_writes", nwr, 320);

    // Reset mid-run
    pulse_start(8'h00);
    run(-1, 100, -1, 101);
    check("rst_no_done", cyc, 2000);
    check("rst_outs", snap, 0);

    // start while busy is ignored
    pulse_start(8'h00);
    run(-1, -1, 200, -1);
    check("busy_start_cyc", cyc, 641);
    check("busy_start_status", status, 32'h8000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
